// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_control_unit_pkg
//  Desc    : Shared opcodes, state encodings and mux selects for the
//            accumulator CPU controller.
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_control_unit_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_STA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_CLA  = 4'd5;
    localparam logic [3:0] OP_SETA = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_JZ   = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic ADDR_PC    = 1'b0;
    localparam logic ADDR_IR    = 1'b1;
    localparam logic PC_SRC_INC = 1'b0;
    localparam logic PC_SRC_IR  = 1'b1;

    // State the controller moves to after DECODE
    typedef enum logic [1:0] {
        CLS_FETCH  = 2'd0,
        CLS_MEM_RD = 2'd1,
        CLS_MEM_WR = 2'd2,
        CLS_HALT   = 2'd3
    } op_class_e;

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_control_unit_if
//  Desc    : Controller <-> datapath/memory strobe bundle. illegal_op exists
//            only when CTRL_ILLEGAL_TRAP_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
interface cpu_control_unit_if #(
    parameter int OPCODE_WIDTH = 4
) ();
    logic [OPCODE_WIDTH-1:0] ir_opcode;
    logic       acc_zero;
    logic       mem_ready;
    logic       pc_en, pc_load, pc_sclr, pc_src;
    logic       ir_en, ir_load, ir_sclr;
    logic       acc_en, acc_load, acc_sclr, acc_sset;
    logic       mem_rd, mem_wr, addr_sel;
    logic [1:0] alu_op;
    logic       halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    modport master (
        input  ir_opcode, acc_zero, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
        output illegal_op,
`endif
        output pc_en, pc_load, pc_sclr, pc_src,
        output ir_en, ir_load, ir_sclr,
        output acc_en, acc_load, acc_sclr, acc_sset,
        output mem_rd, mem_wr, addr_sel, alu_op, halted
    );

    modport slave (
        output ir_opcode, acc_zero, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
        input  illegal_op,
`endif
        input  pc_en, pc_load, pc_sclr, pc_src,
        input  ir_en, ir_load, ir_sclr,
        input  acc_en, acc_load, acc_sclr, acc_sset,
        input  mem_rd, mem_wr, addr_sel, alu_op, halted
    );
endinterface
`default_nettype wire

// File: rtl/cpu_opcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_opcode_decoder
//  Desc    : Combinational opcode -> next-state class / ALU op / illegal flag.
//            CTRL_ILLEGAL_TRAP_EN sends unassigned opcodes to HALT.
//  Rev     : 1.0  initial release
// ============================================================================
module cpu_opcode_decoder
    import cpu_control_unit_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output op_class_e               o_class,
    output logic [1:0]              o_alu_op,
    output logic                    o_illegal
);

    always_comb begin
        o_class   = CLS_FETCH;
        o_alu_op  = ALU_PASS;
        o_illegal = 1'b0;
        case (i_opcode)
            OPCODE_WIDTH'(OP_LDA): o_class = CLS_MEM_RD;
            OPCODE_WIDTH'(OP_ADD): begin
                o_class  = CLS_MEM_RD;
                o_alu_op = ALU_ADD;
            end
            OPCODE_WIDTH'(OP_SUB): begin
                o_class  = CLS_MEM_RD;
                o_alu_op = ALU_SUB;
            end
            OPCODE_WIDTH'(OP_STA): o_class = CLS_MEM_WR;
            OPCODE_WIDTH'(OP_HLT): o_class = CLS_HALT;
            OPCODE_WIDTH'(OP_NOP),
            OPCODE_WIDTH'(OP_CLA),
            OPCODE_WIDTH'(OP_SETA),
            OPCODE_WIDTH'(OP_JMP),
            OPCODE_WIDTH'(OP_JZ):  o_class = CLS_FETCH;
            default: begin
                o_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                o_class   = CLS_HALT;
`else
                o_class   = CLS_FETCH;
`endif
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_control_unit
//  Desc    : Multi-cycle FSM controller for the accumulator CPU; drives PC/IR/
//            ACC strobes and the memory handshake. Option: CTRL_ILLEGAL_TRAP_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    cpu_control_unit_if.master bus
);

    if (OPCODE_WIDTH < 4 || OPCODE_WIDTH > WORD_SIZE) begin : g_width_check
        $error("cpu_control_unit: OPCODE_WIDTH must be within 4..WORD_SIZE");
    end

    logic [2:0] state_q, state_d;
    logic [1:0] alu_op_q, alu_op_d;

    op_class_e  w_dec_class;
    logic [1:0] w_dec_alu;
    logic       w_dec_illegal;

    logic w_pc_load, w_pc_sclr, w_pc_src;
    logic w_ir_load, w_ir_sclr;
    logic w_acc_load, w_acc_sclr, w_acc_sset;
    logic w_mem_rd, w_mem_wr, w_addr_sel, w_halted;
    logic [1:0] w_alu_op;

    cpu_opcode_decoder #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_dec (
        .i_opcode  (bus.ir_opcode),
        .o_class   (w_dec_class),
        .o_alu_op  (w_dec_alu),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        alu_op_d   = alu_op_q;
        w_pc_load  = 1'b0;
        w_pc_sclr  = 1'b0;
        w_pc_src   = PC_SRC_INC;
        w_ir_load  = 1'b0;
        w_ir_sclr  = 1'b0;
        w_acc_load = 1'b0;
        w_acc_sclr = 1'b0;
        w_acc_sset = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_addr_sel = ADDR_PC;
        w_alu_op   = ALU_PASS;
        w_halted   = 1'b0;
        case (state_q)
            S_INIT: begin
                w_pc_sclr  = 1'b1;
                w_ir_sclr  = 1'b1;
                w_acc_sclr = 1'b1;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_load = 1'b1;
                    w_pc_load = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op_d = w_dec_alu;
                case (w_dec_class)
                    CLS_MEM_RD: state_d = S_MEM_RD;
                    CLS_MEM_WR: state_d = S_MEM_WR;
                    CLS_HALT:   state_d = S_HALT;
                    default:    state_d = S_FETCH;
                endcase
                if (bus.ir_opcode == OPCODE_WIDTH'(OP_CLA))  w_acc_sclr = 1'b1;
                if (bus.ir_opcode == OPCODE_WIDTH'(OP_SETA)) w_acc_sset = 1'b1;
                if (bus.ir_opcode == OPCODE_WIDTH'(OP_JMP) ||
                    (bus.ir_opcode == OPCODE_WIDTH'(OP_JZ) && bus.acc_zero)) begin
                    w_pc_load = 1'b1;
                    w_pc_src  = PC_SRC_IR;
                end
            end
            S_MEM_RD: begin
                w_mem_rd   = 1'b1;
                w_addr_sel = ADDR_IR;
                w_alu_op   = alu_op_q;
                if (bus.mem_ready) begin
                    w_acc_load = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM_WR: begin
                w_mem_wr   = 1'b1;
                w_addr_sel = ADDR_IR;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_HALT: w_halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            alu_op_q <= ALU_PASS;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sticky: only a reset clears the trap indication
    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_DECODE && w_dec_illegal) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign bus.illegal_op = illegal_q;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_dec_illegal;
`endif

    assign bus.pc_load  = w_pc_load;
    assign bus.pc_sclr  = w_pc_sclr;
    assign bus.pc_src   = w_pc_src;
    assign bus.pc_en    = w_pc_load | w_pc_sclr;
    assign bus.ir_load  = w_ir_load;
    assign bus.ir_sclr  = w_ir_sclr;
    assign bus.ir_en    = w_ir_load | w_ir_sclr;
    assign bus.acc_load = w_acc_load;
    assign bus.acc_sclr = w_acc_sclr;
    assign bus.acc_sset = w_acc_sset;
    assign bus.acc_en   = w_acc_load | w_acc_sclr | w_acc_sset;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_wr   = w_mem_wr;
    assign bus.addr_sel = w_addr_sel;
    assign bus.alu_op   = w_alu_op;
    assign bus.halted   = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cpu_control_unit
//  Desc    : Random instruction stream against a per-instruction cycle
//            schedule model of the controller.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_control_unit_if #(.OPCODE_WIDTH(4)) bus ();

    cpu_control_unit #(
        .WORD_SIZE    (16),
        .OPCODE_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output vector layout: one bit per strobe, alu_op in [2:1]
    localparam logic [16:0] E_PC_EN    = 17'(1) << 16;
    localparam logic [16:0] E_PC_LOAD  = 17'(1) << 15;
    localparam logic [16:0] E_PC_SCLR  = 17'(1) << 14;
    localparam logic [16:0] E_PC_SRC   = 17'(1) << 13;
    localparam logic [16:0] E_IR_EN    = 17'(1) << 12;
    localparam logic [16:0] E_IR_LOAD  = 17'(1) << 11;
    localparam logic [16:0] E_IR_SCLR  = 17'(1) << 10;
    localparam logic [16:0] E_ACC_EN   = 17'(1) << 9;
    localparam logic [16:0] E_ACC_LOAD = 17'(1) << 8;
    localparam logic [16:0] E_ACC_SCLR = 17'(1) << 7;
    localparam logic [16:0] E_ACC_SSET = 17'(1) << 6;
    localparam logic [16:0] E_MEM_RD   = 17'(1) << 5;
    localparam logic [16:0] E_MEM_WR   = 17'(1) << 4;
    localparam logic [16:0] E_ADDR_SEL = 17'(1) << 3;
    localparam logic [16:0] E_HALTED   = 17'(1);

    logic [16:0] obs;
    assign obs = {bus.pc_en, bus.pc_load, bus.pc_sclr, bus.pc_src,
                  bus.ir_en, bus.ir_load, bus.ir_sclr,
                  bus.acc_en, bus.acc_load, bus.acc_sclr, bus.acc_sset,
                  bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.alu_op, bus.halted};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] with_en(input logic [16:0] v);
        logic [16:0] r;
        r = v;
        if ((v & (E_PC_LOAD | E_PC_SCLR)) != 0)               r = r | E_PC_EN;
        if ((v & (E_IR_LOAD | E_IR_SCLR)) != 0)               r = r | E_IR_EN;
        if ((v & (E_ACC_LOAD | E_ACC_SCLR | E_ACC_SSET)) != 0) r = r | E_ACC_EN;
        return r;
    endfunction

    function automatic logic [16:0] alu_field(input int code);
        return 17'(code) << 1;
    endfunction

    function automatic bit goes_to_halt(input int op);
`ifdef CTRL_ILLEGAL_TRAP_EN
        return op == 15 || (op >= 9 && op <= 14);
`else
        return op == 15;
`endif
    endfunction

    task automatic cyc(input logic rdy, input logic az, input logic [3:0] op,
                       input logic [16:0] exp, input string tag);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.acc_zero  = az;
        bus.ir_opcode = op;
        #1;
        check_eq(tag, obs, with_en(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("init", obs, with_en(E_PC_SCLR | E_IR_SCLR | E_ACC_SCLR));
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("illegal_clr", {16'b0, bus.illegal_op}, 17'd0);
`endif
    endtask

    // One instruction: fw fetch wait cycles, mw operand wait cycles
    task automatic run_instr(input int op, input logic az, input int fw, input int mw);
        logic [16:0] e;
        int          a;
        for (int i = 0; i < fw; i++)
            cyc(1'b0, 1'($urandom), 4'(op), E_MEM_RD, "fetch_wait");
        cyc(1'b1, 1'($urandom), 4'(op), E_MEM_RD | E_IR_LOAD | E_PC_LOAD, "fetch_done");

        e = '0;
        if (op == 5) e = E_ACC_SCLR;
        if (op == 6) e = E_ACC_SSET;
        if (op == 7 || (op == 8 && az)) e = E_PC_LOAD | E_PC_SRC;
        cyc(1'($urandom), az, 4'(op), e, "decode");

        if (op == 1 || op == 3 || op == 4) begin
            a = (op == 1) ? 0 : (op == 3) ? 1 : 2;
            for (int i = 0; i < mw; i++)
                cyc(1'b0, 1'($urandom), 4'($urandom), E_MEM_RD | E_ADDR_SEL | alu_field(a), "rd_wait");
            cyc(1'b1, 1'($urandom), 4'($urandom),
                E_MEM_RD | E_ADDR_SEL | alu_field(a) | E_ACC_LOAD, "rd_done");
        end else if (op == 2) begin
            for (int i = 0; i < mw; i++)
                cyc(1'b0, 1'($urandom), 4'($urandom), E_MEM_WR | E_ADDR_SEL, "wr_wait");
            cyc(1'b1, 1'($urandom), 4'($urandom), E_MEM_WR | E_ADDR_SEL, "wr_done");
        end else if (goes_to_halt(op)) begin
            for (int i = 0; i < 20; i++)
                cyc(1'($urandom), 1'($urandom), 4'($urandom), E_HALTED, "halt");
`ifdef CTRL_ILLEGAL_TRAP_EN
            check_eq("illegal_op", {16'b0, bus.illegal_op}, {16'b0, (op != 15)});
`endif
            do_reset();
        end
    endtask

    initial begin
        int op;
        bus.mem_ready = 1'b0;
        bus.acc_zero  = 1'b0;
        bus.ir_opcode = '0;

        do_reset();
        run_instr(0, 1'b0, 3, 0);   // fetch held 4 cycles
        run_instr(3, 1'b0, 0, 0);   // ADD, ready tied high
        run_instr(8, 1'b0, 0, 0);   // JZ not taken
        run_instr(8, 1'b1, 0, 0);   // JZ taken
        run_instr(6, 1'b0, 0, 0);
        run_instr(5, 1'b0, 0, 0);
        run_instr(10, 1'b0, 1, 0);
        run_instr(4, 1'b1, 2, 3);
        run_instr(2, 1'b0, 1, 2);
        run_instr(15, 1'b0, 0, 0);

        // Reset while a fetch is waiting, then while an operand read waits
        cyc(1'b0, 1'b0, 4'd1, E_MEM_RD, "fetch_wait");
        do_reset();
        cyc(1'b1, 1'b0, 4'd1, E_MEM_RD | E_IR_LOAD | E_PC_LOAD, "fetch_done");
        cyc(1'b0, 1'b0, 4'd1, '0, "decode");
        cyc(1'b0, 1'b0, 4'd1, E_MEM_RD | E_ADDR_SEL, "rd_wait");
        do_reset();

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 15));
            if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
            run_instr(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
